// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port dmem arbiter/sequencer.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   localparam int   DMEM_DEPTH = 512;
   localparam logic PORT_CPU   = 1'b0;
   localparam logic PORT_DBG   = 1'b1;

   function automatic logic [1:0] port_onehot(input logic p);
      return (p == PORT_CPU) ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and dmem-side bus of the arbiter; slave = arbiter, master = requesters + memory.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1, err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_dataIn, mem_dataOut;
   logic              mem_readmode, mem_writemode;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataOut,
      output ack0, ack1, err0, err1, rdata0, rdata1,
             mem_address, mem_dataIn, mem_readmode, mem_writemode
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataOut,
      input  ack0, ack1, err0, err1, rdata0, rdata1,
             mem_address, mem_dataIn, mem_readmode, mem_writemode
   );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin pick; a tie goes to the port that did not win last.
module rr_arbiter2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   input  logic       enable_i,
   output logic [1:0] grant_o
);
   always_comb begin
      grant_o = 2'b00;
      if (enable_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = port_onehot(~last_grant_i);
            default: grant_o = 2'b00;
         endcase
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto a transition-sensitive dmem: IDLE -> SETUP -> STROBE -> DONE,
// with address settled a cycle before and after the single mode strobe.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = DMEM_DEPTH
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);
   state_e                  state_q, state_d;
   logic                    last_q, last_d, port_q, port_d, we_q, we_d;
   logic                    rmode_q, rmode_d, wmode_q, wmode_d;
   logic [1:0]              ack_q, ack_d, err_q, err_d;
   logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
   logic [ADDR_W-1:0]       maddr_q, maddr_d;
   logic [DATA_W-1:0]       mdin_q, mdin_d;

   logic [1:0]              grant;
   logic                    win, win_we, win_oor;
   logic [ADDR_W-1:0]       win_addr;
   logic [DATA_W-1:0]       win_wdata;

   rr_arbiter2 u_rr (
      .req_i        ({bus.req1, bus.req0}),
      .last_grant_i (last_q),
      .enable_i     (state_q == S_IDLE),
      .grant_o      (grant)
   );

   assign win       = grant[1];
   assign win_we    = win ? bus.we1    : bus.we0;
   assign win_addr  = win ? bus.addr1  : bus.addr0;
   assign win_wdata = win ? bus.wdata1 : bus.wdata0;
   assign win_oor   = (win_addr >= ADDR_W'(MEM_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= PORT_DBG;
         port_q  <= PORT_CPU;
         we_q    <= 1'b0;
         rmode_q <= 1'b0;
         wmode_q <= 1'b0;
         ack_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
         maddr_q <= '0;
         mdin_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         port_q  <= port_d;
         we_q    <= we_d;
         rmode_q <= rmode_d;
         wmode_q <= wmode_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         maddr_q <= maddr_d;
         mdin_q  <= mdin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      port_d  = port_q;
      we_d    = we_q;
      rmode_d = 1'b0;
      wmode_d = 1'b0;
      ack_d   = '0;
      err_d   = '0;
      rdata_d = rdata_q;
      maddr_d = maddr_q;
      mdin_d  = mdin_q;
      case (state_q)
         S_IDLE: begin
            if (|grant) begin
               port_d = win;
               last_d = win;
               we_d   = win_we;
               if (win_oor) begin
                  // No memory cycle at all: mem_* keep their old values.
                  ack_d[win] = 1'b1;
                  err_d[win] = 1'b1;
                  if (!win_we) rdata_d[win] = '0;
                  state_d = S_DONE;
               end else begin
                  maddr_d = win_addr;
                  if (win_we) mdin_d = win_wdata;
                  state_d = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            rmode_d = ~we_q;
            wmode_d = we_q;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (!we_q) rdata_d[port_q] = bus.mem_dataOut;
            ack_d[port_q] = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.ack0          = ack_q[0];
   assign bus.ack1          = ack_q[1];
   assign bus.err0          = err_q[0];
   assign bus.err1          = err_q[1];
   assign bus.rdata0        = rdata_q[0];
   assign bus.rdata1        = rdata_q[1];
   assign bus.mem_address   = maddr_q;
   assign bus.mem_dataIn    = mdin_q;
   assign bus.mem_readmode  = rmode_q;
   assign bus.mem_writemode = wmode_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an edge-triggered dmem model.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(512)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [0:511];
   always @(posedge bus.mem_writemode) mem[bus.mem_address[8:0]] = bus.mem_dataIn;
   always @(posedge bus.mem_readmode)  bus.mem_dataOut = mem[bus.mem_address[8:0]];

   int n_chk = 0, n_err = 0;
   int n_rd = 0, n_wr = 0, n_both = 0;
   always @(negedge clk) begin
      if (bus.mem_readmode)  n_rd++;
      if (bus.mem_writemode) n_wr++;
      if (bus.mem_readmode && bus.mem_writemode) n_both++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int p, input logic rq, input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
      if (p == 0) begin
         bus.req0 = rq; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
      end else begin
         bus.req1 = rq; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the following IDLE.
   task automatic access(input string tag, input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd,
                         input logic exp_err);
      int cyc = 0;
      bit seen = 0;
      int rd0 = n_rd, wr0 = n_wr;
      logic [31:0] other;
      other = (p == 0) ? bus.rdata1 : bus.rdata0;
      drive(p, 1'b1, we, a, wd);
      while (!seen && cyc < 20) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         seen = (p == 0) ? bus.ack0 : bus.ack1;
      end
      drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
      chk($sformatf("%s_lat", tag), 64'(cyc), 64'(exp_lat));
      chk($sformatf("%s_err", tag), (p == 0) ? bus.err0 : bus.err1, exp_err);
      chk($sformatf("%s_other_ack", tag), (p == 0) ? bus.ack1 : bus.ack0, 0);
      chk($sformatf("%s_other_rdata", tag), (p == 0) ? bus.rdata1 : bus.rdata0, other);
      if (!we) chk($sformatf("%s_rdata", tag), (p == 0) ? bus.rdata0 : bus.rdata1, exp_rd);
      chk($sformatf("%s_nrd", tag), 64'(n_rd - rd0), (!we && !exp_err) ? 1 : 0);
      chk($sformatf("%s_nwr", tag), 64'(n_wr - wr0), (we && !exp_err) ? 1 : 0);
      @(negedge clk);
   endtask

   initial begin
      int t0, t1, n, cnt;
      int ord [4];
      int tm [4];
      logic [31:0] a_before;

      for (int i = 0; i < 512; i++) mem[i] = 32'd0;
      mem[7]  = 32'h7777_0007;
      mem[10] = 32'h0A0A_1010;
      mem[11] = 32'h1B1B_1111;
      bus.mem_dataOut = 32'd0;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

      // Reset state
      rst = 1'b1;
      #12;
      chk("rst_ack", {bus.ack1, bus.ack0}, 0);
      chk("rst_err", {bus.err1, bus.err0}, 0);
      chk("rst_rdata", {bus.rdata1, bus.rdata0}, 0);
      chk("rst_maddr", bus.mem_address, 0);
      chk("rst_mdin", bus.mem_dataIn, 0);
      chk("rst_modes", {bus.mem_readmode, bus.mem_writemode}, 0);
      @(negedge clk); rst = 1'b0;

      // Simultaneous reads right after reset: port 0 first, port 1 four cycles later
      drive(0, 1'b1, 1'b0, 32'd10, 32'd0);
      drive(1, 1'b1, 1'b0, 32'd11, 32'd0);
      t0 = 0; t1 = 0;
      for (int c = 1; c <= 20 && (t0 == 0 || t1 == 0); c++) begin
         @(posedge clk); @(negedge clk);
         if (bus.ack0) begin t0 = c; drive(0, 1'b0, 1'b0, 32'd0, 32'd0); end
         if (bus.ack1) begin t1 = c; drive(1, 1'b0, 1'b0, 32'd0, 32'd0); end
      end
      chk("tie_ack0_cyc", 64'(t0), 3);
      chk("tie_ack1_cyc", 64'(t1), 7);
      chk("tie_rdata0", bus.rdata0, 32'h0A0A_1010);
      chk("tie_rdata1", bus.rdata1, 32'h1B1B_1111);
      @(negedge clk);

      // Write then read on port 0
      access("wr5", 0, 1'b1, 32'd5, 32'hDEAD_BEEF, 3, 32'd0, 1'b0);
      chk("wr5_mem", mem[5], 32'hDEAD_BEEF);
      access("rd5", 0, 1'b0, 32'd5, 32'd0, 3, 32'hDEAD_BEEF, 1'b0);

      // Both ports held for four accesses after a fresh reset: grants 0,1,0,1
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      drive(0, 1'b1, 1'b0, 32'd10, 32'd0);
      drive(1, 1'b1, 1'b1, 32'd20, 32'h1234_5678);
      n = 0;
      for (int c = 1; c <= 40 && n < 4; c++) begin
         @(posedge clk); @(negedge clk);
         if (bus.ack0) begin ord[n] = 0; tm[n] = c; n++; end
         else if (bus.ack1) begin ord[n] = 1; tm[n] = c; n++; end
         if (n == 4) begin
            drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
            drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
         end
      end
      chk("rr_count", 64'(n), 4);
      for (int k = 0; k < n; k++) begin
         chk($sformatf("rr_port%0d", k), 64'(ord[k]), 64'(k % 2));
         chk($sformatf("rr_cyc%0d", k), 64'(tm[k]), 64'(3 + 4 * k));
      end
      chk("rr_mem20", mem[20], 32'h1234_5678);
      chk("rr_rdata0", bus.rdata0, 32'h0A0A_1010);
      @(negedge clk);

      // Out-of-range read on port 1: immediate ack, err, rdata cleared, no strobe
      a_before = bus.mem_address;
      access("oor", 1, 1'b0, 32'd512, 32'd0, 1, 32'd0, 1'b1);
      chk("oor_maddr_held", bus.mem_address, a_before);

      // Reset while a write strobe is high
      drive(0, 1'b1, 1'b1, 32'd30, 32'hCAFE_0000);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("mid_wmode", bus.mem_writemode, 1);
      rst = 1'b1;
      #1;
      chk("mid_modes", {bus.mem_readmode, bus.mem_writemode}, 0);
      chk("mid_ack", {bus.ack1, bus.ack0}, 0);
      chk("mid_maddr", bus.mem_address, 0);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk); rst = 1'b0;
      access("post_rst", 0, 1'b0, 32'd5, 32'd0, 3, 32'hDEAD_BEEF, 1'b0);

      // Port 1 drops req one cycle after being sampled
      drive(1, 1'b1, 1'b0, 32'd7, 32'd0);
      @(posedge clk); @(negedge clk);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); @(negedge clk);
         if (bus.ack1) cnt++;
      end
      chk("drop_ack_count", 64'(cnt), 1);
      chk("drop_rdata1", bus.rdata1, 32'h7777_0007);

      chk("never_both_modes", 64'(n_both), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
